// File: rtl/lock_pkg.sv
// Shared definitions for the lock access controller: state encoding, default
// timing parameters and the failure-counter width.
package lock_pkg;

  localparam int unsigned FAIL_W            = 4;
  localparam int unsigned STATE_W           = 3;
  localparam int unsigned DEF_MAX_FAILS     = 3;
  localparam int unsigned DEF_EVAL_DELAY    = 2;
  localparam int unsigned DEF_UNLOCK_TICKS  = 50;
  localparam int unsigned DEF_LOCKOUT_TICKS = 200;
  localparam int unsigned DEF_CNT_W         = 8;

  // Encoding is visible on the debug/display port, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    StIdle   = 3'd0,
    StEval   = 3'd1,
    StOpen   = 3'd2,
    StLocked = 3'd3,
    StAlarm  = 3'd4
  } lock_state_e;

  // Failure counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lock_tick_timer.sv
// Loadable down-counter advanced by a tick enable. Saturates at zero; a load
// in the same cycle as a tick wins over the decrement.
module lock_tick_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: load has priority, then tick-driven decrement to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
  // One tick away from expiring; lets the owner leave on the reaching edge.
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lock_access_ctrl.sv
// Lock sequencer: evaluates keypad entries against the profile match,
// counts consecutive failures, enforces a timed lockout and latches tamper.
module lock_access_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS     = DEF_MAX_FAILS,
  parameter int unsigned EVAL_DELAY    = DEF_EVAL_DELAY,
  parameter int unsigned UNLOCK_TICKS  = DEF_UNLOCK_TICKS,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               entry_done,
  input  logic               match,
  input  logic               tamper,
  input  logic               admin_clear,
  output logic               unlock,
  output logic               lockout,
  output logic               alarm,
  output logic               clear_entry,
  output logic [FAIL_W-1:0]  fail_cnt,
  output logic [STATE_W-1:0] state
);

  localparam logic [FAIL_W-1:0] MaxFailsW = FAIL_W'(MAX_FAILS);
  localparam logic [2:0]        EvalDlyW  = 3'(EVAL_DELAY);
  localparam logic [CNT_W-1:0]  UnlockW   = CNT_W'(UNLOCK_TICKS);
  localparam logic [CNT_W-1:0]  LockoutW  = CNT_W'(LOCKOUT_TICKS);

  lock_state_e       state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [2:0]        dly_q, dly_d;
  logic              entry_q;
  logic              entry_rise;
  logic              clear_d;
  logic              unlock_q, lockout_q, alarm_q, clear_q;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero, tmr_last, tmr_expire;

  assign entry_rise = entry_done & ~entry_q;
  // Timer is zero now, or becomes zero on this edge's tick.
  assign tmr_expire = tmr_zero | (tick & tmr_last);

  lock_tick_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero),
    .last    (tmr_last)
  );

  // Next-state, failure count, evaluation delay and timer load decisions.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    dly_d    = dly_q;
    clear_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (tamper) begin
      state_d = StAlarm;
    end else begin
      case (state_q)
        StIdle: begin
          if (entry_rise) begin
            state_d = StEval;
            dly_d   = EvalDlyW;
          end
        end
        StEval: begin
          if (dly_q == '0) begin
            clear_d = 1'b1;
            if (match) begin
              state_d  = StOpen;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = UnlockW;
            end else begin
              fail_d = sat_inc(fail_q);
              if (fail_d >= MaxFailsW) begin
                state_d  = StLocked;
                tmr_load = 1'b1;
                tmr_val  = LockoutW;
              end else begin
                state_d = StIdle;
              end
            end
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        StOpen: begin
          if (tmr_expire) begin
            state_d = StIdle;
          end
        end
        StLocked: begin
          if (admin_clear || tmr_expire) begin
            state_d  = StIdle;
            fail_d   = '0;
            tmr_load = 1'b1;
          end
        end
        StAlarm: begin
          // tamper is already known low on this branch
          if (admin_clear) begin
            state_d  = StIdle;
            fail_d   = '0;
            tmr_load = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      fail_q    <= '0;
      dly_q     <= '0;
      entry_q   <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      alarm_q   <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      dly_q     <= dly_d;
      entry_q   <= entry_done;
      unlock_q  <= (state_d == StOpen);
      lockout_q <= (state_d == StLocked) || (state_d == StAlarm);
      alarm_q   <= (state_d == StAlarm);
      clear_q   <= clear_d;
    end
  end

  assign unlock      = unlock_q;
  assign lockout     = lockout_q;
  assign alarm       = alarm_q;
  assign clear_entry = clear_q;
  assign fail_cnt    = fail_q;
  assign state       = state_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Bench for lock_access_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of the lock rules.
module tb_lock_access_ctrl;

  localparam int MaxFails     = 3;
  localparam int EvalDelay    = 2;
  localparam int UnlockTicks  = 50;
  localparam int LockoutTicks = 200;

  localparam int MIdle   = 0;
  localparam int MEval   = 1;
  localparam int MOpen   = 2;
  localparam int MLocked = 3;
  localparam int MAlarm  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, entry_done, match, tamper, admin_clear;
  logic       unlock, lockout, alarm, clear_entry;
  logic [3:0] fail_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // model state
  int m_mode, m_fail, m_timer, m_wait;
  bit m_prev, m_clr;

  // observation counters
  int tick_pct = 100;
  int ut, lt, cp;

  always #5 clk = ~clk;

  lock_access_ctrl #(
    .MAX_FAILS    (MaxFails),
    .EVAL_DELAY   (EvalDelay),
    .UNLOCK_TICKS (UnlockTicks),
    .LOCKOUT_TICKS(LockoutTicks),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .entry_done (entry_done),
    .match      (match),
    .tamper     (tamper),
    .admin_clear(admin_clear),
    .unlock     (unlock),
    .lockout    (lockout),
    .alarm      (alarm),
    .clear_entry(clear_entry),
    .fail_cnt   (fail_cnt),
    .state      (state)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_mode = MIdle; m_fail = 0; m_timer = 0; m_wait = 0; m_prev = 0; m_clr = 0;
  endtask

  // One clock edge of the lock rules, using the inputs present at that edge.
  task automatic model_step;
    bit rise;
    int ns, nt, nf;
    rise   = entry_done && !m_prev;
    m_prev = entry_done;
    m_clr  = 0;
    ns     = m_mode;
    nf     = m_fail;
    nt     = (tick && m_timer > 0) ? m_timer - 1 : m_timer;
    if (tamper) ns = MAlarm;
    else begin
      case (m_mode)
        MIdle: if (rise) begin ns = MEval; m_wait = EvalDelay; end
        MEval: begin
          if (m_wait == 0) begin
            m_clr = 1;
            if (match) begin
              ns = MOpen; nf = 0; nt = UnlockTicks;
            end else begin
              nf = (m_fail < 15) ? m_fail + 1 : 15;
              if (nf >= MaxFails) begin ns = MLocked; nt = LockoutTicks; end
              else ns = MIdle;
            end
          end else m_wait--;
        end
        MOpen:   if (nt == 0) ns = MIdle;
        MLocked: if (admin_clear || nt == 0) begin ns = MIdle; nf = 0; end
        MAlarm:  if (admin_clear) begin ns = MIdle; nf = 0; nt = 0; end
        default: ns = MIdle;
      endcase
    end
    m_mode = ns; m_fail = nf; m_timer = nt;
  endtask

  // Advance one clock: choose tick, step DUT and model, compare on the falling edge.
  task automatic cyc;
    tick = ($urandom_range(99) < tick_pct);
    if (unlock && tick) ut++;
    if (lockout && !alarm && tick) lt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("state", state, m_mode);
    check("fail_cnt", fail_cnt, m_fail);
    check("unlock", unlock, m_mode == MOpen);
    check("lockout", lockout, (m_mode == MLocked) || (m_mode == MAlarm));
    check("alarm", alarm, m_mode == MAlarm);
    check("clear_entry", clear_entry, m_clr);
    if (clear_entry) cp++;
  endtask

  task automatic enter(input bit m);
    entry_done = 1; match = m;
    repeat (EvalDelay + 3) cyc();
    entry_done = 0;
    cyc();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int n = 0;
    while (state != target && n < budget) begin
      cyc();
      n++;
    end
    check(tag, state, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; tick = 0; entry_done = 0; match = 0; tamper = 0; admin_clear = 0;
    model_reset();
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_unlock", unlock, 0);
    check("rst_lockout", lockout, 0);
    check("rst_fail", fail_cnt, 0);
    rst = 0;
    cyc();

    // correct code
    ut = 0; cp = 0;
    enter(1);
    check("t1_unlock", unlock, 1);
    check("t1_fail", fail_cnt, 0);
    wait_state(MIdle, 300, "t1_idle");
    check("t1_ticks", ut, UnlockTicks);
    check("t1_clr", cp, 1);

    // three wrong codes, ignored fourth, lockout expiry
    enter(0); check("t2_f1", fail_cnt, 1);
    enter(0); check("t2_f2", fail_cnt, 2);
    lt = 0;
    enter(0);
    check("t2_lock", lockout, 1);
    check("t2_f3", fail_cnt, 3);
    enter(0);
    check("t2_ign_f", fail_cnt, 3);
    check("t2_ign_s", state, MLocked);
    wait_state(MIdle, 600, "t2_idle");
    check("t2_ticks", lt, LockoutTicks);
    check("t2_f0", fail_cnt, 0);

    // partial failures then success
    enter(0); check("t3_f1", fail_cnt, 1);
    enter(0); check("t3_f2", fail_cnt, 2);
    enter(1);
    check("t3_f0", fail_cnt, 0);
    check("t3_unlock", unlock, 1);
    check("t3_nolock", lockout, 0);
    wait_state(MIdle, 300, "t3_idle");

    // tamper during open
    enter(1);
    repeat (10) cyc();
    tamper = 1; cyc();
    check("t4_unlock", unlock, 0);
    check("t4_alarm", alarm, 1);
    admin_clear = 1; cyc(); admin_clear = 0; cyc();
    check("t4_held", alarm, 1);
    tamper = 0; cyc();
    check("t4_held2", alarm, 1);
    admin_clear = 1; cyc(); admin_clear = 0;
    check("t4_idle", state, MIdle);
    check("t4_clr", alarm, 0);

    // level hold: one evaluation only
    cp = 0;
    entry_done = 1; match = 0;
    repeat (500) cyc();
    entry_done = 0; cyc();
    check("t5_evals", cp, 1);
    check("t5_fail", fail_cnt, 1);

    // async reset mid-lockout
    enter(0);
    enter(0);
    check("t6_lock", lockout, 1);
    repeat (20) cyc();
    #2 rst = 1;
    #1;
    check("t6_lockout", lockout, 0);
    check("t6_state", state, 0);
    check("t6_clr", clear_entry, 0);
    check("t6_fail", fail_cnt, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("t6_clr2", clear_entry, 0);
    rst = 0;
    cyc();

    // random traffic
    tick_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) entry_done = ~entry_done;
      match       = $urandom_range(1);
      tamper      = ($urandom_range(299) == 0) ? 1'b1 : (tamper && ($urandom_range(3) != 0));
      admin_clear = ($urandom_range(39) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
Sequences the lock around the keypad/profile datapath. It takes the keypad "entry done" level and the profile-match result and drives the unlock output. It counts consecutive failed attempts, enforces a timed lockout after MAX_FAILS failures, and latches a tamper alarm. It sits between the keypad/profile modules and the door/LED outputs, on the divided clock domain.

Parameters:
MAX_FAILS, 3, consecutive failures that trigger lockout (1..15)
EVAL_DELAY, 2, clk cycles between entry_done rise and sampling match (1..7)
UNLOCK_TICKS, 50, tick pulses the unlock output stays asserted (1..2^CNT_W-1)
LOCKOUT_TICKS, 200, tick pulses of lockout (1..2^CNT_W-1)
CNT_W, 8, width of the tick timer

Ports:
clk  in  1  system clock (divided clock domain)
rst  in  1  reset; asynchronous, active-high
tick  in  1  single-cycle timebase enable for timers
entry_done  in  1  keypad code-complete level (held high while code is presented)
match  in  1  profile comparison result, valid EVAL_DELAY cycles after entry_done rises
tamper  in  1  debounced tamper/motion flag
admin_clear  in  1  single-cycle pulse that clears alarm and lockout
unlock  out  1  door release
lockout  out  1  lockout active
alarm  out  1  latched tamper alarm
clear_entry  out  1  one-cycle pulse requesting a keypad entry reset
fail_cnt  out  4  current consecutive-failure count
state  out  3  encoded FSM state for debug/display

Behaviour:
- Reset (async, rst=1): state=IDLE, fail_cnt=0, timer=0, all outputs 0, and the entry_done edge register=0.
- The entry_done rising edge is detected with a one-flop history. Only a rising edge starts an evaluation, so a held level never retriggers.
- IDLE: on an entry_done rise, go to EVAL and load the delay counter with EVAL_DELAY.
- EVAL: count down each clk. At zero, sample match:
  - match=1: go to OPEN, set fail_cnt=0, load timer with UNLOCK_TICKS.
  - match=0: increment fail_cnt (saturating at 15). If the new fail_cnt >= MAX_FAILS, go to LOCKED and load timer with LOCKOUT_TICKS. Otherwise go to IDLE.
  - In either case, pulse clear_entry for 1 cycle on the exit transition.
- OPEN: unlock=1. Decrement timer on tick. When the timer reaches 0, go to IDLE with unlock=0 on the same edge. Entry_done rises during OPEN are ignored.
- LOCKED: lockout=1. Decrement on tick and ignore entry_done.
  - Timer at 0: go to IDLE with fail_cnt=0.
  - admin_clear: go to IDLE immediately with fail_cnt=0.
- ALARM: entered from any state when tamper=1 is sampled. This has the highest priority over all other transitions in that cycle.
  - Outputs: alarm=1, unlock forced 0, lockout held at 1.
  - Stays in ALARM until admin_clear=1 with tamper=0. It then goes to IDLE with fail_cnt=0 and timer=0.
  - admin_clear while tamper=1 is ignored.
- Simultaneous tick and state entry: the timer load takes precedence over the decrement.
- Timer decrement: saturates at 0 and never wraps.
- Outputs are registered and update one cycle after their cause.
- State encoding: IDLE=0, EVAL=1, OPEN=2, LOCKED=3, ALARM=4. Values 5..7 are illegal and recover to IDLE.
- Reset mid-operation: the async clear takes effect immediately. No clear_entry pulse is generated.

Decomposition:
- Shared package lock_pkg holds:
  - the state encoding constants,
  - the default MAX_FAILS/UNLOCK_TICKS/LOCKOUT_TICKS values,
  - FAIL_W=4.
- One sub-module, lock_tick_timer: a loadable down-counter with tick enable, a zero flag and saturation. It is shared by the OPEN and LOCKED states, and the EVAL delay uses a small separate counter.

Test Plan:
- Correct code: entry_done rises with match=1 at EVAL_DELAY. Required: unlock=1 for exactly 50 ticks, fail_cnt=0, clear_entry pulses once.
- Three wrong codes: three entry_done rises with match=0. Required: fail_cnt steps 1, 2, then lockout=1. A fourth entry is ignored. Lockout releases after 200 ticks with fail_cnt=0.
- Partial failures then success: two wrong codes followed by a correct one. Required: fail_cnt goes 1, 2, then 0, and unlock asserts with no lockout.
- Tamper during OPEN: tamper=1 mid-unlock. Required next cycle: unlock=0, alarm=1. admin_clear with tamper=1 leaves alarm held. admin_clear with tamper=0 returns to IDLE.
- Level hold: entry_done held high for 500 cycles. Required: exactly one evaluation occurs.
- Async reset: rst asserted mid-LOCKED, between clock edges. Required: lockout=0 and state=0 immediately, with no clear_entry pulse.
